game_controller: RTL and testbench

Rally sequencer for the volleyball game, clocked on the 65 MHz pixel clock. It owns the match state (idle, serve, play, point pause, game over), counts scores and touches, and tells the ball physics and drawing blocks when to reset, run or freeze. It replaces the unconnected judge score outputs as the single source of match state.

---
 rtl/game_controller_if.sv | 31 +++
 rtl/game_controller.sv | 210 +++++++++++++++++++++
 tb/tb_game_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_controller_if.sv
// game_controller_if: bundles the rally sequencer's event inputs and match-state outputs.
//   master : the environment side (physics, judge, mouse). It drives the events and reads the match state.
//   slave  : the sequencer side. It reads the events and drives the match state.
// Event inputs : frame_tick, click_p1, click_p2, floor_hit, ball_side, touch_p1, touch_p2
// State outputs: state, physics_en, ball_reset, serve_side, score_p1, score_p2, winner
interface game_controller_if;
    logic       frame_tick;
    logic       click_p1;
    logic       click_p2;
    logic       floor_hit;
    logic       ball_side;
    logic       touch_p1;
    logic       touch_p2;
    logic [2:0] state;
    logic       physics_en;
    logic       ball_reset;
    logic       serve_side;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       winner;

    modport master (
        output frame_tick, click_p1, click_p2, floor_hit, ball_side, touch_p1, touch_p2,
        input  state, physics_en, ball_reset, serve_side, score_p1, score_p2, winner
    );

    modport slave (
        input  frame_tick, click_p1, click_p2, floor_hit, ball_side, touch_p1, touch_p2,
        output state, physics_en, ball_reset, serve_side, score_p1, score_p2, winner
    );
endinterface

// File: rtl/game_controller.sv
// game_controller: rally sequencer for the volleyball game.
// It owns the match state (idle, serve, play, point pause, game over).
// It counts the scores and the consecutive touches of each side.
// It tells the physics and drawing blocks when to reset, run or freeze.
// Ports:
//   pclk : 65 MHz pixel clock. All logic runs on its rising edge.
//   rst  : synchronous reset, active low.
//   gif  : slave side of game_controller_if (event inputs, registered match-state outputs).
module game_controller #(
    parameter int WIN_SCORE    = 15,
    parameter int MAX_TOUCHES  = 3,
    parameter int POINT_FRAMES = 90,
    parameter int SERVE_FRAMES = 180
) (
    input  logic              pclk,
    input  logic              rst,
    game_controller_if.slave  gif
);
    localparam int TW = $clog2(MAX_TOUCHES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic          physics_en_r, physics_en_s;
    logic          ball_reset_r, ball_reset_s;
    logic          serve_side_r, serve_side_s;
    logic [3:0]    score_p1_r, score_p1_s;
    logic [3:0]    score_p2_r, score_p2_s;
    logic          winner_r, winner_s;
    logic [TW-1:0] touch_cnt_r, touch_cnt_s;
    logic          last_touch_r, last_touch_s;
    logic [7:0]    frame_cnt_r, frame_cnt_s;
    logic          click_p1_r, click_p2_r;

    logic          edge_p1_s, edge_p2_s;
    logic          award_s, scorer_s;
    logic [TW-1:0] play_cnt_s;
    logic          play_last_s;
    logic          toucher_s;
    logic [3:0]    new_score_s;

    // Scores stop at the top of their 4-bit range instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Click edges compare the button level against its value one cycle earlier.
    always_comb begin
        edge_p1_s = gif.click_p1 & ~click_p1_r;
        edge_p2_s = gif.click_p2 & ~click_p2_r;
    end

    // Rally judging in PLAY: floor hits beat touches, at most one point per cycle.
    always_comb begin
        award_s     = 1'b0;
        scorer_s    = 1'b0;
        play_cnt_s  = touch_cnt_r;
        play_last_s = last_touch_r;
        // A simultaneous double touch is credited to the player whose half holds the ball.
        toucher_s   = (gif.touch_p1 & gif.touch_p2) ? gif.ball_side : gif.touch_p2;
        if (gif.floor_hit) begin
            award_s  = 1'b1;
            scorer_s = ~gif.ball_side;
        end else if (gif.touch_p1 | gif.touch_p2) begin
            if (toucher_s == last_touch_r) begin
                if (touch_cnt_r >= TW'(MAX_TOUCHES)) begin
                    award_s  = 1'b1;
                    scorer_s = ~toucher_s;
                end else begin
                    play_cnt_s = touch_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end else begin
                play_cnt_s  = {{(TW-1){1'b0}}, 1'b1};
                play_last_s = toucher_s;
            end
        end else begin
            award_s = 1'b0;
        end
        new_score_s = scorer_s ? sat_inc(score_p2_r) : sat_inc(score_p1_r);
    end

    // Next-state and next-output logic of the match FSM.
    always_comb begin
        state_s      = state_r;
        ball_reset_s = 1'b0;
        serve_side_s = serve_side_r;
        score_p1_s   = score_p1_r;
        score_p2_s   = score_p2_r;
        winner_s     = winner_r;
        touch_cnt_s  = touch_cnt_r;
        last_touch_s = last_touch_r;
        frame_cnt_s  = frame_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_p1_s | edge_p2_s) begin
                    state_s      = ST_SERVE;
                    score_p1_s   = 4'd0;
                    score_p2_s   = 4'd0;
                    serve_side_s = 1'b0;
                    ball_reset_s = 1'b1;
                    frame_cnt_s  = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                // The tick that brings the count to SERVE_FRAMES launches the serve in the same edge.
                if ((serve_side_r ? edge_p2_s : edge_p1_s) ||
                    (gif.frame_tick && (frame_cnt_r == 8'(SERVE_FRAMES - 1)))) begin
                    state_s      = ST_PLAY;
                    frame_cnt_s  = 8'd0;
                    touch_cnt_s  = {TW{1'b0}};
                    last_touch_s = 1'b0;
                end else if (gif.frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 8'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            ST_PLAY: begin
                if (award_s) begin
                    if (scorer_s) begin
                        score_p2_s = new_score_s;
                    end else begin
                        score_p1_s = new_score_s;
                    end
                    serve_side_s = scorer_s;
                    frame_cnt_s  = 8'd0;
                    if (new_score_s >= 4'(WIN_SCORE)) begin
                        state_s  = ST_OVER;
                        winner_s = scorer_s;
                    end else begin
                        state_s = ST_POINT;
                    end
                end else begin
                    touch_cnt_s  = play_cnt_s;
                    last_touch_s = play_last_s;
                end
            end
            ST_POINT: begin
                if (gif.frame_tick && (frame_cnt_r == 8'(POINT_FRAMES - 1))) begin
                    state_s      = ST_SERVE;
                    ball_reset_s = 1'b1;
                    frame_cnt_s  = 8'd0;
                end else if (gif.frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 8'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            ST_OVER: begin
                // Scores stay on screen through IDLE until the next serve clears them.
                if (edge_p1_s | edge_p2_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        physics_en_s = (state_s == ST_PLAY);
    end

    // State and output registers. The active-low reset wins over every event.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            physics_en_r <= 1'b0;
            ball_reset_r <= 1'b0;
            serve_side_r <= 1'b0;
            score_p1_r   <= 4'd0;
            score_p2_r   <= 4'd0;
            winner_r     <= 1'b0;
            touch_cnt_r  <= {TW{1'b0}};
            last_touch_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
            click_p1_r   <= 1'b0;
            click_p2_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            physics_en_r <= physics_en_s;
            ball_reset_r <= ball_reset_s;
            serve_side_r <= serve_side_s;
            score_p1_r   <= score_p1_s;
            score_p2_r   <= score_p2_s;
            winner_r     <= winner_s;
            touch_cnt_r  <= touch_cnt_s;
            last_touch_r <= last_touch_s;
            frame_cnt_r  <= frame_cnt_s;
            click_p1_r   <= gif.click_p1;
            click_p2_r   <= gif.click_p2;
        end
    end

    assign gif.state      = state_r;
    assign gif.physics_en = physics_en_r;
    assign gif.ball_reset = ball_reset_r;
    assign gif.serve_side = serve_side_r;
    assign gif.score_p1   = score_p1_r;
    assign gif.score_p2   = score_p2_r;
    assign gif.winner     = winner_r;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: scoreboard bench for game_controller.
// The stimulus pushes each expected output change, tagged with the cycle it must appear in.
// A negedge monitor pops one entry whenever the outputs change or ball_reset is high.
module tb_game_controller;
    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    game_controller_if gif();

    game_controller #(
        .WIN_SCORE(15), .MAX_TOUCHES(3), .POINT_FRAMES(90), .SERVE_FRAMES(180)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .gif(gif.slave)
    );

    typedef struct {
        logic [2:0]  st;
        logic        pe;
        logic        br;
        logic        ss;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        w;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [13:0] cur_v, prev_v;

    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: every output change, and every cycle with ball_reset high, consumes one expectation.
    always @(negedge pclk) begin
        cur_v = {gif.state, gif.physics_en, gif.serve_side, gif.score_p1, gif.score_p2, gif.winner};
        if (mon_on && ((cur_v !== prev_v) || (gif.ball_reset === 1'b1))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got st=%0d pe=%0d br=%0d ss=%0d s1=%0d s2=%0d w=%0d",
                         cyc, gif.state, gif.physics_en, gif.ball_reset, gif.serve_side,
                         gif.score_p1, gif.score_p2, gif.winner);
            end else begin
                mon_e = exp_q.pop_front();
                if ({gif.state, gif.physics_en, gif.ball_reset, gif.serve_side,
                     gif.score_p1, gif.score_p2, gif.winner} !==
                    {mon_e.st, mon_e.pe, mon_e.br, mon_e.ss, mon_e.s1, mon_e.s2, mon_e.w} ||
                    cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL event cyc=%0d got st=%0d pe=%0d br=%0d ss=%0d s1=%0d s2=%0d w=%0d required cyc=%0d st=%0d pe=%0d br=%0d ss=%0d s1=%0d s2=%0d w=%0d",
                             cyc, gif.state, gif.physics_en, gif.ball_reset, gif.serve_side,
                             gif.score_p1, gif.score_p2, gif.winner,
                             mon_e.cyc, mon_e.st, mon_e.pe, mon_e.br, mon_e.ss,
                             mon_e.s1, mon_e.s2, mon_e.w);
                end
            end
        end
        prev_v = cur_v;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Expected outputs one edge after the inputs that are about to be driven.
    task automatic expect_ev(input logic [2:0] st, input logic pe, input logic br,
                             input logic ss, input logic [3:0] s1, input logic [3:0] s2,
                             input logic w);
        exp_t e;
        e.st = st; e.pe = pe; e.br = br; e.ss = ss;
        e.s1 = s1; e.s2 = s2; e.w = w;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic press(input int who);
        if (who == 1) gif.click_p1 = 1'b1; else gif.click_p2 = 1'b1;
        step();
        gif.click_p1 = 1'b0;
        gif.click_p2 = 1'b0;
        step();
    endtask

    task automatic tick();
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic touch(input logic t1, input logic t2);
        gif.touch_p1 = t1;
        gif.touch_p2 = t2;
        step();
        gif.touch_p1 = 1'b0;
        gif.touch_p2 = 1'b0;
        step();
    endtask

    task automatic floor(input logic side);
        gif.ball_side = side;
        gif.floor_hit = 1'b1;
        step();
        gif.floor_hit = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        gif.frame_tick = 1'b0; gif.click_p1 = 1'b0; gif.click_p2 = 1'b0;
        gif.floor_hit = 1'b0; gif.ball_side = 1'b0;
        gif.touch_p1 = 1'b0; gif.touch_p2 = 1'b0;
        repeat (3) step();

        // Reset values.
        checks++;
        if ({gif.state, gif.physics_en, gif.ball_reset, gif.serve_side,
             gif.score_p1, gif.score_p2, gif.winner} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d pe=%0d br=%0d ss=%0d s1=%0d s2=%0d w=%0d required all 0",
                     gif.state, gif.physics_en, gif.ball_reset, gif.serve_side,
                     gif.score_p1, gif.score_p2, gif.winner);
        end
        mon_on = 1'b1;
        rst = 1'b1;
        step();

        // IDLE -> SERVE on a click edge. Holding the button must not retrigger.
        gif.click_p1 = 1'b1;
        expect_ev(3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        repeat (10) step();
        gif.click_p1 = 1'b0;
        step();

        // Automatic serve on the 180th frame tick.
        frames(179);
        expect_ev(3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        tick();

        // Floor on the left half: P2 scores and serves. Then the point pause.
        expect_ev(3'd3, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0);
        floor(1'b0);
        frames(89);
        expect_ev(3'd1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
        tick();
        press(1);  // the non-server's click is ignored
        expect_ev(3'd2, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0);
        press(2);

        // A fourth consecutive P1 touch faults to P2.
        touch(1'b1, 1'b0); touch(1'b1, 1'b0); touch(1'b1, 1'b0);
        expect_ev(3'd3, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0);
        touch(1'b1, 1'b0);
        frames(89);
        expect_ev(3'd1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0);
        tick();
        expect_ev(3'd2, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0);
        press(2);

        // p1,p1,p2,p2,p2 gives no point. Then three P1 touches, and a floor hit on the right half
        // in the same cycle as the fourth: only P1 scores.
        touch(1'b1, 1'b0); touch(1'b1, 1'b0);
        touch(1'b0, 1'b1); touch(1'b0, 1'b1); touch(1'b0, 1'b1);
        touch(1'b1, 1'b0); touch(1'b1, 1'b0); touch(1'b1, 1'b0);
        gif.ball_side = 1'b1;
        gif.floor_hit = 1'b1;
        expect_ev(3'd3, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        touch(1'b1, 1'b0);
        gif.floor_hit = 1'b0;
        frames(89);
        expect_ev(3'd1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        tick();
        expect_ev(3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        press(1);

        // A double touch with the ball on the left counts as P1's fourth touch.
        touch(1'b1, 1'b0); touch(1'b1, 1'b0); touch(1'b1, 1'b0);
        gif.ball_side = 1'b0;
        expect_ev(3'd3, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b0);
        touch(1'b1, 1'b1);
        frames(89);
        expect_ev(3'd1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd3, 1'b0);
        tick();
        expect_ev(3'd2, 1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 1'b0);
        press(2);

        // Reset in the middle of a rally.
        rst = 1'b0;
        expect_ev(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        rst = 1'b1;
        step();
        expect_ev(3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        press(2);
        expect_ev(3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        press(1);

        // P1 wins 15-0.
        for (int k = 1; k <= 15; k++) begin
            if (k < 15) expect_ev(3'd3, 1'b0, 1'b0, 1'b0, 4'(k), 4'd0, 1'b0);
            else        expect_ev(3'd4, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0);
            floor(1'b1);
            if (k < 15) begin
                frames(89);
                expect_ev(3'd1, 1'b0, 1'b1, 1'b0, 4'(k), 4'd0, 1'b0);
                tick();
                expect_ev(3'd2, 1'b1, 1'b0, 1'b0, 4'(k), 4'd0, 1'b0);
                press(1);
            end
        end

        // In OVER a floor hit is ignored. A click returns to IDLE with the scores held,
        // and the next serve clears them.
        floor(1'b1);
        expect_ev(3'd0, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0);
        press(2);
        expect_ev(3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        press(1);
        repeat (4) step();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending events required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
